fpadder: RTL and testbench
==========================

Name: fpadder

Overview:
- Sequential IEEE-754 single-precision adder with one serial operand port.
- Pulses `ready`, then takes operand A and operand B from `a` on fixed later clock edges, adds them over several cycles, and publishes the result on `sum` with another `ready` pulse.
- Used as a small shared FP add engine wherever a low-area, multi-cycle adder is acceptable.

Parameters:
- None. Format is fixed binary32: 1 sign bit, 8 exponent bits, bias 127, 23 fraction bits.

Ports:
- `clock`  input  1  rising-edge clock.
- `nreset`  input  1  synchronous, active-high reset.
- `a`  input  32  serial operand input, binary32.
- `sum`  output  32  registered result, binary32.
- `ready`  output  1  registered one-cycle pulse marking operand window open / result valid.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- While `nreset` is high at a clock edge: FSM goes to IDLE, `sum` = 32'h0, `ready` = 0, all internal registers cleared.
- Reset asserted mid-operation abandons the operation immediately; no partial result is ever published.
- FSM states: IDLE, READY, GETA, GETB, ALIGN, ADD, NORM, ROUND.
- Transitions, one per edge when not in reset: IDLE→READY→GETA→GETB→ALIGN→ADD→NORM→ROUND→READY.
- `ready` = 1 exactly while in READY (one cycle per pass), otherwise 0.
- Let E be the edge that enters READY:
  - operand A is registered from `a` at edge E+2 (the edge leaving GETA);
  - operand B is registered at edge E+3 (the edge leaving GETB);
  - the result is written to `sum` at edge E+7, the same edge that re-enters READY and raises `ready`.
- Throughput is one addition per 7 cycles. Latency from the B-capture edge to `ready` high is 4 edges.
- `sum` holds its value between result writes, so it is stable during and after the `ready` pulse until the next result.
- `a` is ignored in all states except at the two capture edges.
- Datapath by state:
  - ALIGN: unpack both operands, swap so the larger magnitude is first, right-shift the smaller significand by the exponent difference. Keep guard, round and sticky bits; shifts of 26 or more collapse into sticky.
  - ADD: add or subtract significands (27-bit incl. GRS, plus carry bit) according to the sign XOR.
  - NORM: on carry, shift right 1 and increment the exponent; otherwise left-shift by the leading-zero count and decrement the exponent.
  - ROUND: round to nearest, ties to even; a rounding carry-out renormalizes. Then pack.
- Special cases:
  - Subnormal inputs are flushed to signed zero.
  - Results whose exponent underflows are flushed to +0.
  - Exponent overflow gives signed infinity.
  - Any NaN input, or (+inf)+(−inf), gives 32'h7FC00000.
  - inf plus a finite value gives that inf.
  - An exact zero result is +0, except (−0)+(−0) = −0.

Decomposition:
- Package `fpadder_pkg` holds:
  - the packed struct for binary32 fields (sign, exp, frac);
  - constants EXP_BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, POS_INF=32'h7F800000;
  - the FSM state enum.
- One natural sub-module, `fp_lzc_norm`: combinational leading-zero count plus left shift of the 27-bit significand, returning the shifted value and the shift amount.

Test Plan:
- Reset, then release: `ready` pulses high for one cycle; `sum` = 0. Drive A=42.135 (32'h4228_8A3D) at E+2 and B=−0.135 (32'hBE0A_3D71) at E+3 → at E+7 `ready` = 1 and `sum` = 32'h4228_0000 (42.0).
- 1.0 + 1.0 (32'h3F80_0000 twice) → 32'h4000_0000; 1.0 + −1.0 → 32'h0000_0000.
- Rounding: 1.0 + 32'h3380_0000 (2^−24, tie) → 32'h3F80_0000; 1.0 + 32'h33C0_0000 → 32'h3F80_0001.
- Overflow and specials:
  - 32'h7F7F_FFFF + 32'h7F7F_FFFF → 32'h7F80_0000;
  - 32'h7F80_0000 + 32'hFF80_0000 → 32'h7FC0_0000;
  - NaN + 1.0 → 32'h7FC0_0000.
- Reset asserted during ADD → next cycle `ready` = 0 and `sum` = 0; after release, a new READY pulse appears and a fresh 2.0 + 3.0 gives 32'h40A0_0000.
- Back-to-back: two consecutive operations 7 cycles apart each produce the correct `sum`; `sum` stays unchanged while `a` toggles outside the capture edges.

Source files
------------

// File: rtl/fpadder_pkg.sv
// Shared types and constants for the serial binary32 adder.
// Holds the field layout, the special encodings and the controller states.
package fpadder_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  localparam int          EXP_BIAS = 127;
  localparam int          EXP_MAX  = 255;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF  = 32'h7F80_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READY,
    S_GETA,
    S_GETB,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND
  } state_e;

endpackage

// File: rtl/fp_lzc_norm.sv
// Leading-zero count of a 27-bit significand and the matching left shift.
// An all-zero input reports a count of 27 and returns zero.
module fp_lzc_norm
  import fpadder_pkg::*;
(
  input  logic [26:0] sig_i,
  output logic [26:0] sig_o,
  output logic [4:0]  shamt_o
);

  always_comb begin
    shamt_o = 5'd27;
    // Scanning upward lets the highest set bit set the final count.
    for (int i = 0; i < 27; i++) begin
      if (sig_i[i]) shamt_o = 5'(26 - i);
    end
    sig_o = sig_i << shamt_o;
  end

endmodule

// File: rtl/fpadder.sv
// Multi-cycle binary32 adder: captures A then B from one serial port, then
// aligns, adds, normalizes and rounds (nearest-even) before publishing sum.
module fpadder
  import fpadder_pkg::*;
(
  input  logic        clock,
  input  logic        nreset,
  input  logic [31:0] a,
  output logic [31:0] sum,
  output logic        ready
);

  state_e             state_q, state_d;
  logic [31:0]        op_a_q, op_a_d, op_b_q, op_b_d;
  logic [31:0]        sum_q, sum_d;
  logic               ready_q, ready_d;
  logic               sign_q, sign_d, eff_sub_q, eff_sub_d;
  logic               special_q, special_d;
  logic [31:0]        special_val_q, special_val_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [26:0]        big_q, big_d, small_q, small_d;
  logic [27:0]        sig_q, sig_d;

  fp32_t              fa, fb, op_big;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap, sticky;
  logic [7:0]         exp_diff;
  logic [26:0]        big_sig, small_sig, small_shr, small_al;
  logic [26:0]        lzc_sig;
  logic [4:0]         lzc_shamt;
  logic [23:0]        mant;
  logic [24:0]        mant_r;
  logic [22:0]        frac_r;
  logic               round_up;
  logic signed [9:0]  exp_r;
  logic [31:0]        result;

  fp_lzc_norm u_lzc (
    .sig_i  (sig_q[26:0]),
    .sig_o  (lzc_sig),
    .shamt_o(lzc_shamt)
  );

  // Unpack and align; subnormals are treated as zero throughout.
  always_comb begin
    fa       = fp32_t'(op_a_q);
    fb       = fp32_t'(op_b_q);
    a_zero   = (fa.exp == 8'd0);
    b_zero   = (fb.exp == 8'd0);
    a_inf    = (fa.exp == 8'(EXP_MAX)) && (fa.frac == 23'd0);
    b_inf    = (fb.exp == 8'(EXP_MAX)) && (fb.frac == 23'd0);
    a_nan    = (fa.exp == 8'(EXP_MAX)) && (fa.frac != 23'd0);
    b_nan    = (fb.exp == 8'(EXP_MAX)) && (fb.frac != 23'd0);
    swap     = (b_zero ? 31'd0 : op_b_q[30:0]) > (a_zero ? 31'd0 : op_a_q[30:0]);
    op_big   = swap ? fb : fa;
    big_sig  = (swap ? b_zero : a_zero) ? 27'd0 : {1'b1, op_big.frac, 3'b000};
    small_sig = (swap ? a_zero : b_zero) ? 27'd0 :
                {1'b1, (swap ? fa.frac : fb.frac), 3'b000};
    exp_diff  = op_big.exp - (swap ? fa.exp : fb.exp);
    small_shr = small_sig >> exp_diff;
    sticky    = |(small_sig & ((27'd1 << exp_diff) - 27'd1));
    if (exp_diff >= 8'd26) small_al = {26'd0, |small_sig};
    else                   small_al = {small_shr[26:1], small_shr[0] | sticky};
  end

  always_comb begin
    mant     = sig_q[26:3];
    round_up = sig_q[2] & (sig_q[1] | sig_q[0] | sig_q[3]);
    mant_r   = {1'b0, mant} + {24'd0, round_up};
    exp_r    = exp_q + (mant_r[24] ? 10'sd1 : 10'sd0);
    frac_r   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
    if (special_q)                             result = special_val_q;
    else if (sig_q == 28'd0)                   result = 32'h0;
    else if (exp_r >= $signed(10'(EXP_MAX)))   result = {sign_q, POS_INF[30:0]};
    else if (exp_r <= 10'sd0)                  result = 32'h0;
    else                                       result = {sign_q, exp_r[7:0], frac_r};
  end

  always_comb begin
    // NOTE: every _d holds its flop by default first, so no path infers a latch.
    state_d       = state_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    sum_d         = sum_q;
    sign_d        = sign_q;
    eff_sub_d     = eff_sub_q;
    special_d     = special_q;
    special_val_d = special_val_q;
    exp_d         = exp_q;
    big_d         = big_q;
    small_d       = small_q;
    sig_d         = sig_q;
    unique case (state_q)
      S_IDLE:  state_d = S_READY;
      S_READY: state_d = S_GETA;
      S_GETA: begin
        state_d = S_GETB;
        op_a_d  = a;
      end
      S_GETB: begin
        state_d = S_ALIGN;
        op_b_d  = a;
      end
      S_ALIGN: begin
        state_d       = S_ADD;
        sign_d        = op_big.sign;
        eff_sub_d     = fa.sign ^ fb.sign;
        exp_d         = $signed({2'b00, op_big.exp});
        big_d         = big_sig;
        small_d       = small_al;
        special_d     = a_nan | b_nan | a_inf | b_inf | (a_zero & b_zero);
        if (a_nan || b_nan || (a_inf && b_inf && (fa.sign != fb.sign)))
          special_val_d = QNAN;
        else if (a_inf)  special_val_d = op_a_q;
        else if (b_inf)  special_val_d = op_b_q;
        else             special_val_d = {fa.sign & fb.sign, 31'd0};
      end
      S_ADD: begin
        state_d = S_NORM;
        sig_d   = eff_sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                            : ({1'b0, big_q} + {1'b0, small_q});
      end
      S_NORM: begin
        state_d = S_ROUND;
        if (sig_q[27]) begin
          sig_d = {1'b0, sig_q[27:2], sig_q[1] | sig_q[0]};
          exp_d = exp_q + 10'sd1;
        end else begin
          sig_d = {1'b0, lzc_sig};
          exp_d = exp_q - $signed({5'd0, lzc_shamt});
        end
      end
      S_ROUND: begin
        state_d = S_READY;
        sum_d   = result;
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_READY);
  end

  // NOTE: non-blocking assignments make every flop sample pre-edge values.
  always_ff @(posedge clock) begin
    if (nreset) begin
      state_q       <= S_IDLE;
      op_a_q        <= '0;
      op_b_q        <= '0;
      sum_q         <= '0;
      ready_q       <= 1'b0;
      sign_q        <= 1'b0;
      eff_sub_q     <= 1'b0;
      special_q     <= 1'b0;
      special_val_q <= '0;
      exp_q         <= '0;
      big_q         <= '0;
      small_q       <= '0;
      sig_q         <= '0;
    end else begin
      state_q       <= state_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      sum_q         <= sum_d;
      ready_q       <= ready_d;
      sign_q        <= sign_d;
      eff_sub_q     <= eff_sub_d;
      special_q     <= special_d;
      special_val_q <= special_val_d;
      exp_q         <= exp_d;
      big_q         <= big_d;
      small_q       <= small_d;
      sig_q         <= sig_d;
    end
  end

  assign sum   = sum_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_fpadder.sv
// Bench for fpadder: directed cases from the datasheet plus random operands
// checked against an exact-arithmetic binary32 reference model.
module tb_fpadder;
  import fpadder_pkg::*;

  logic        clock  = 1'b0;
  logic        nreset = 1'b1;
  logic [31:0] a      = '0;
  logic [31:0] sum;
  logic        ready;
  int          tests_run    = 0;
  int          tests_failed = 0;

  fpadder dut (
    .clock (clock),
    .nreset(nreset),
    .a     (a),
    .sum   (sum),
    .ready (ready)
  );

  always #5 clock = ~clock;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Exact sum on wide integers, then one round-to-nearest-even to 24 bits.
  function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
    fp32_t        fx, fy;
    logic [299:0] mx, my, mag, kept, rem, half;
    logic         sgn, x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
    int           ex, ey, emin, p, shift, unbiased, biased;
    fx = x;
    fy = y;
    x_nan  = (fx.exp == 8'hFF) && (fx.frac != 0);
    y_nan  = (fy.exp == 8'hFF) && (fy.frac != 0);
    x_inf  = (fx.exp == 8'hFF) && (fx.frac == 0);
    y_inf  = (fy.exp == 8'hFF) && (fy.frac == 0);
    x_zero = (fx.exp == 8'h00);
    y_zero = (fy.exp == 8'h00);
    if (x_nan || y_nan || (x_inf && y_inf && fx.sign != fy.sign)) return QNAN;
    if (x_inf) return x;
    if (y_inf) return y;
    if (x_zero && y_zero) return {fx.sign & fy.sign, 31'd0};
    ex = int'(fx.exp);
    ey = int'(fy.exp);
    if (x_zero) ex = ey;
    if (y_zero) ey = ex;
    mx = x_zero ? '0 : {276'd0, 1'b1, fx.frac};
    my = y_zero ? '0 : {276'd0, 1'b1, fy.frac};
    emin = (ex < ey) ? ex : ey;
    mx = mx << (ex - emin);
    my = my << (ey - emin);
    if (fx.sign == fy.sign) begin mag = mx + my; sgn = fx.sign; end
    else if (mx >= my)      begin mag = mx - my; sgn = fx.sign; end
    else                    begin mag = my - mx; sgn = fy.sign; end
    if (mag == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    shift = p - 23;
    if (shift > 0) begin
      kept = mag >> shift;
      rem  = mag - (kept << shift);
      half = 300'd1 << (shift - 1);
      if (rem > half || (rem == half && kept[0])) kept = kept + 1;
      if (kept[24]) begin kept = kept >> 1; shift++; end
    end else begin
      kept = mag << (-shift);
    end
    // value = mag * 2^(emin - bias - 23) = (kept / 2^23) * 2^(emin + shift - bias)
    unbiased = emin + shift - EXP_BIAS;
    biased   = unbiased + EXP_BIAS;
    if (biased >= EXP_MAX) return {sgn, POS_INF[30:0]};
    if (biased <= 0) return 32'h0;
    return {sgn, 8'(biased), kept[22:0]};
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check32({tag, "_ready_seen"}, {31'd0, ready}, 32'd1);
  endtask

  // Called at the falling edge just after READY was entered (edge E).
  task automatic run_op(input string tag, input logic [31:0] op_a,
                        input logic [31:0] op_b, input logic [31:0] expected);
    logic [31:0] held;
    logic        hold_ok;
    held    = sum;
    hold_ok = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      a = (c == 2) ? op_a : (c == 3) ? op_b : $urandom();
      @(negedge clock);
      if (c < 7 && (ready !== 1'b0 || sum !== held)) hold_ok = 1'b0;
    end
    a = $urandom();
    check32({tag, "_hold"}, {31'd0, hold_ok}, 32'd1);
    check32({tag, "_ready"}, {31'd0, ready}, 32'd1);
    check32(tag, sum, expected);
  endtask

  initial begin
    logic [31:0] x, y;

    nreset = 1'b1;
    repeat (3) @(negedge clock);
    check32("reset_ready", {31'd0, ready}, 32'd0);
    check32("reset_sum", sum, 32'h0);
    nreset = 1'b0;
    wait_ready("first");
    check32("first_sum", sum, 32'h0);

    run_op("sub_42",    32'h4228_8A3D, 32'hBE0A_3D71, 32'h4228_0000);
    run_op("one_one",   32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
    run_op("one_mone",  32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000);
    run_op("tie_even",  32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);
    run_op("round_up",  32'h3F80_0000, 32'h33C0_0000, 32'h3F80_0001);
    run_op("overflow",  32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
    run_op("inf_minf",  32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
    run_op("nan_one",   32'h7FC1_2345, 32'h3F80_0000, 32'h7FC0_0000);
    run_op("minf_fin",  32'hFF80_0000, 32'h4120_0000, 32'hFF80_0000);
    run_op("mz_mz",     32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    run_op("sub_flush", 32'h0040_0000, 32'hC000_0000, 32'hC000_0000);
    run_op("underflow", 32'h0080_0001, 32'h8080_0000, 32'h0000_0000);

    // Abort during ADD: entered at E+4, reset sampled at E+5.
    for (int c = 1; c <= 4; c++) begin
      a = $urandom();
      @(negedge clock);
    end
    nreset = 1'b1;
    @(negedge clock);
    check32("abort_ready", {31'd0, ready}, 32'd0);
    check32("abort_sum", sum, 32'h0);
    @(negedge clock);
    nreset = 1'b0;
    wait_ready("after_abort");
    check32("after_abort_sum", sum, 32'h0);
    run_op("two_three", 32'h4000_0000, 32'h4040_0000, 32'h40A0_0000);

    for (int i = 0; i < 40; i++) begin
      x = $urandom();
      y = $urandom();
      if (i % 2 == 0) y[30:23] = x[30:23] + 8'($urandom_range(0, 6)) - 8'd3;
      if (i % 5 == 0) y[31] = ~x[31];
      run_op($sformatf("rand%0d", i), x, y, ref_add(x, y));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
